// File: rtl/sipo_pkg.sv
// Shared types and defaults for the PISO/SIPO serial link pair.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } sipo_state_t;

  localparam int unsigned SIPO_WIDTH = 8;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH strobed bits into a word and
// presents it on a one-entry valid/ready buffer with a sticky overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             shift,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             overrun
);

  sipo_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg_q[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (clear) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (shift) begin
      sreg_d = shifted;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = RECV;
      end
    end

    // The final bit goes straight from serial_in into the buffer via 'shifted'.
    if (complete) begin
      if (!valid_q || data_ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign bit_count  = cnt_q;
  assign busy       = (state_q == RECV);
  assign overrun    = ovr_q;

endmodule : sipo_deserializer

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel receiver that consumes the single-bit stream produced by the team's PISO shift register. It accumulates WIDTH bits qualified by a shift strobe into a parallel word. It then presents the word on a one-entry valid/ready output buffer. Word overruns are flagged when the downstream does not drain the buffer in time.

Parameters:
WIDTH, 8, word length in bits (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1] (matches PISO shifting out MSB first); 0 = first bit lands in data_out[0]
CNT_W, $clog2(WIDTH), width of bit_count (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
serial_in  input  1  serial data bit, sampled only when shift=1
shift  input  1  bit-valid strobe; one bit captured per clk edge where shift=1
clear  input  1  synchronous abort of partial word and overrun clear
data_out  output  WIDTH  completed word (output buffer)
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  downstream accepts word when data_valid && data_ready at clk edge
bit_count  output  CNT_W  bits captured in current partial word, 0..WIDTH-1
busy  output  1  partial word in progress (state RECV)
overrun  output  1  sticky: a completed word was dropped because the buffer was full

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values (reset_n=0, async):
  - shift register=0, bit_count=0, state=IDLE
  - data_out=0, data_valid=0, overrun=0, busy=0
- Receive FSM (busy = state==RECV):
  - IDLE: shift=1 -> capture bit, bit_count=1, go to RECV.
  - RECV: shift=1 and bit_count<WIDTH-1 -> capture bit, bit_count+1.
  - RECV: shift=1 and bit_count==WIDTH-1 -> word complete, bit_count wraps to 0, go to IDLE.
  - shift=0 -> hold; no timeout. Gaps between bits are legal.
- Capture:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - Completed word = sreg after including the final bit (the final bit bypasses sreg into data_out on the same edge).
- Latency: data_valid rises on the clk edge that samples the WIDTH-th bit. It is visible the cycle after that bit is presented.
- Output buffer:
  - Load on completion if data_valid=0, or if data_valid && data_ready on that same edge. Simultaneous drain and refill is lossless; data_valid stays 1 with the new word.
  - Completion while data_valid=1 and data_ready=0: word dropped, data_out/data_valid unchanged, overrun <= 1.
  - data_valid && data_ready with no completion: data_valid <= 0. data_out holds its last value.
  - data_out is stable while data_valid=1 and data_ready=0.
- clear=1:
  - bit_count<=0, sreg<=0, state<=IDLE, overrun<=0.
  - clear has priority over shift on the same edge; that bit is discarded.
  - The output buffer (data_out/data_valid) is not affected; a same-cycle handshake still completes.
- Reset mid-word: partial word lost, all outputs to reset values immediately (async).
- bit_count never equals WIDTH.
- No X propagation: serial_in is ignored when shift=0.

Decomposition:
- Shared package sipo_pkg: state enum {IDLE, RECV}, and a localparam default SIPO_WIDTH=8 for the PISO/SIPO pair.
- Single module; no sub-module is natural at this size.
- The output buffer stays inline (≈150 lines RTL).

Test Plan:
1. Reset, then shift bits 1,1,0,1,0,1,0,1 on 8 consecutive cycles, data_ready=1 -> data_valid=1 for one cycle with data_out=8'hD5; busy=1 during bits 1-7; bit_count 1..7 then 0.
2. MSB_FIRST=0, same bit sequence -> data_out=8'hAB.
3. Two back-to-back words 8'hD5, 8'h3C, data_ready=0 throughout -> data_out=8'hD5 held, overrun=1 after the 16th bit; then data_ready=1 -> data_valid drops, data_out stays 8'hD5.
4. Word 8'hD5 completes on the same edge the prior word 8'h3C is accepted (data_ready=1) -> data_valid stays 1, data_out=8'hD5, overrun=0.
5. Shift 3 bits, assert clear together with a 4th shift -> bit_count=0, busy=0, overrun=0; a following full 8-bit word 8'hD5 is received correctly.
6. Shift 5 bits with idle gaps of 0-3 cycles, pulse reset_n low mid-cycle -> all outputs 0 immediately; the next 8 bits produce a correct word.
